dds_rom_sequencer: RTL and testbench
====================================

# dds_rom_sequencer

Two-channel DDS address sequencer for the 400-entry × 8-bit waveform ROM (distributed ROM, unregistered output, one combinational read port). It keeps a fractional phase accumulator per channel, wraps it modulo 400, and time-shares the single ROM port between the two channels on alternate cycles. It captures each channel's sample and takes per-channel frequency and phase updates over a valid/ready config port. It sits between the system control logic and the ROM, and feeds the DAC output stage.

## Interface
- DEPTH, 400: ROM entries; the phase integer part wraps modulo DEPTH.
- ADDR_W, 9: ROM address width; requires 2^ADDR_W ≥ DEPTH.
- DATA_W, 8: sample width.
- FRAC_W, 8: fractional phase bits.

- clk  in  1  single system clock.
- rst_n  in  1  asynchronous, active-low reset.
- rom_addr  out  ADDR_W  ROM address; registered.
- rom_rd_data  in  DATA_W  ROM data; combinational from rom_addr in the same cycle.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accepted when cfg_valid & cfg_ready are high at an edge.
- cfg_ch  in  1  target channel.
- cfg_en  in  1  channel run enable.
- cfg_clr  in  1  clear accumulator on apply.
- cfg_step  in  ADDR_W+FRAC_W  phase step {int, frac}.
- cfg_poff  in  ADDR_W  phase offset.
- cfg_err  out  1  one-cycle pulse: request rejected.
- ch0_data, ch1_data  out  DATA_W  latest sample per channel.
- ch0_valid, ch1_valid  out  1  one-cycle strobe per new sample.

## Operation
- Reset values:
  - rom_addr=0, rom_ch=1, so the first issue edge serves ch0.
  - Both accumulators, steps and offsets = 0; both channels disabled.
  - chN_data=0, chN_valid=0, cfg_ready=1, cfg_err=0, no pending config.
- Slot rotation, every edge:
  - rom_ch ← ~rom_ch.
  - rom_addr ← addr(k), where k = ~rom_ch (the channel being issued).
  - addr(k) = acc_int(k) + poff(k), minus DEPTH if the sum is ≥ DEPTH.
- Capture, same edge: rom_rd_data is stored into ch[rom_ch]_data and ch[rom_ch]_valid pulses, but only if that channel was enabled when its address was issued. A registered issue-active bit travels with rom_addr to track this.
- Accumulator update for channel k at its issue edge, when enabled:
  - sum = acc + step, with frac carry into int.
  - int = acc_int + step_int + carry; subtract DEPTH if ≥ DEPTH. The sum is always < 2·DEPTH, so one conditional subtract suffices.
- Disabled channel: accumulator holds, chN_data holds, no valid strobe. Its address is still issued; ROM reads are harmless.
- Config:
  - Acceptance: a request with step_int ≥ DEPTH or poff ≥ DEPTH is rejected. cfg_err pulses the next cycle and no state changes.
  - A valid request is latched as pending and cfg_ready drops.
  - Apply happens at the target channel's next issue edge. It loads step, poff and en. If cfg_clr is set, the accumulator goes to 0 and that edge issues addr = poff_new; otherwise it issues with the new poff.
  - cfg_ready returns high the cycle after apply.
  - Requests arriving while cfg_ready=0 are not accepted; they are not errors.
- Reset mid-operation returns every output and register to its reset value at once. Pending config is discarded.

## Timing
- Each channel is issued every 2 cycles, so the per-channel sample rate is clk/2.
- Address-issue edge to sample: chN_data updates and chN_valid pulses at the following edge, 1 cycle after rom_addr changes.
- Config accept to apply: 1–2 cycles. Config accept to first sample with new settings: 2–3 cycles.
- cfg_err is a 1-cycle pulse in the cycle after the rejected request's edge.
- Simultaneous events:
  - Apply and accumulator update at the same edge: the new step takes effect from the next update onward. The current update uses the old step, unless cfg_clr is set, in which case clear wins.
  - Enabling with cfg_en=0 applied: the accumulator freezes at that edge.

## Structure
- Package dds_pkg holds DEPTH, ADDR_W, DATA_W, FRAC_W defaults and a phase struct {int, frac}.
- The modulo-DEPTH adder (sum plus conditional subtract) is one sub-module, dds_mod_add, instantiated for the accumulator and for the offset add of each channel.
- The ROM is instantiated outside this block.

## Test plan
- Reset, then ch0 with step=1.0 and poff=0, using a ROM model with data = addr[7:0]: ch0_valid every 2nd cycle, data 0,1,2…; addr 399 is followed by 0.
- ch0 step=3.5 (int 3, frac 0x80), ch1 step=1.0 poff=200, both enabled: ch0 addrs 0,3,7,10,14…; ch1 addrs 200…399,0; outputs interleave ch0/ch1 every cycle.
- Step int=399 with frac accumulating a carry: sum ≥ DEPTH wraps correctly, e.g. acc 398.128 + 399.128 → 398.0.
- Rejection: step_int=400 and poff=450 → cfg_err pulses once per request; addresses and outputs are unchanged.
- Back-to-back cfg_valid: the second request is held while cfg_ready=0 and accepted after apply. A cfg_clr apply issues addr=poff_new at that channel's next slot.
- rst_n asserted mid-run with a pending config: all outputs go to zero immediately and cfg_ready=1. After release, channels are disabled and no valid strobes occur until a new config.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared constants and the fixed-point phase type for the DDS sequencer.
package dds_pkg;
  localparam int DEPTH  = 400;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int FRAC_W = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] ip;
    logic [FRAC_W-1:0] fp;
  } phase_t;
endpackage

// File: rtl/dds_mod_add.sv
// Modulo-DEPTH adder: a + b + cin with one conditional subtract (operands < DEPTH).
module dds_mod_add #(
  parameter int DEPTH  = dds_pkg::DEPTH,
  parameter int ADDR_W = dds_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] a_i,
  input  logic [ADDR_W-1:0] b_i,
  input  logic              cin_i,
  output logic [ADDR_W-1:0] sum_o
);
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W:0] raw;
  logic [ADDR_W:0] wrapped;

  assign raw     = {1'b0, a_i} + {1'b0, b_i} + {{ADDR_W{1'b0}}, cin_i};
  assign wrapped = raw - DEPTH_V;
  assign sum_o   = (raw >= DEPTH_V) ? wrapped[ADDR_W-1:0] : raw[ADDR_W-1:0];
endmodule

// File: rtl/dds_rom_sequencer.sv
// Two-channel DDS sequencer sharing one combinational ROM port on alternate cycles,
// with a valid/ready config port that applies at the target channel's next issue slot.
module dds_rom_sequencer
  import dds_pkg::phase_t;
#(
  parameter int DEPTH  = dds_pkg::DEPTH,
  parameter int ADDR_W = dds_pkg::ADDR_W,
  parameter int DATA_W = dds_pkg::DATA_W,
  parameter int FRAC_W = dds_pkg::FRAC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_rd_data,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic                     cfg_ch,
  input  logic                     cfg_en,
  input  logic                     cfg_clr,
  input  logic [ADDR_W+FRAC_W-1:0] cfg_step,
  input  logic [ADDR_W-1:0]        cfg_poff,
  output logic                     cfg_err,
  output logic [DATA_W-1:0]        ch0_data,
  output logic [DATA_W-1:0]        ch1_data,
  output logic                     ch0_valid,
  output logic                     ch1_valid
);
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  logic                    rom_ch_q, rom_ch_d;
  logic                    issue_act_q, issue_act_d;
  logic [ADDR_W-1:0]       rom_addr_q, rom_addr_d;
  logic                    pend_q, pend_d;
  logic                    pend_ch_q, pend_en_q, pend_clr_q;
  phase_t                  pend_step_q;
  logic [ADDR_W-1:0]       pend_poff_q;
  logic                    cfg_err_q, cfg_err_d;
  logic                    accept, bad_req, apply_any;
  logic [1:0][ADDR_W-1:0]  issue_addr;
  logic [1:0]              en_eff;
  logic [1:0]              valid_vec;
  logic [1:0][DATA_W-1:0]  data_vec;

  assign cfg_ready = ~pend_q;
  assign accept    = cfg_valid & cfg_ready;
  assign bad_req   = ({1'b0, cfg_step[ADDR_W+FRAC_W-1:FRAC_W]} >= DEPTH_V) |
                     ({1'b0, cfg_poff} >= DEPTH_V);
  // The channel being issued this edge is ~rom_ch_q.
  assign apply_any = pend_q & (pend_ch_q == ~rom_ch_q);

  always_comb begin
    rom_ch_d    = ~rom_ch_q;
    rom_addr_d  = rom_ch_q ? issue_addr[0] : issue_addr[1];
    issue_act_d = rom_ch_q ? en_eff[0] : en_eff[1];
    cfg_err_d   = accept & bad_req;
    pend_d      = pend_q;
    if (apply_any) begin
      pend_d = 1'b0;
    end else if (accept & ~bad_req) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_ch_q    <= 1'b1;
      issue_act_q <= 1'b0;
      rom_addr_q  <= '0;
      pend_q      <= 1'b0;
      pend_ch_q   <= 1'b0;
      pend_en_q   <= 1'b0;
      pend_clr_q  <= 1'b0;
      pend_step_q <= '0;
      pend_poff_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      rom_ch_q    <= rom_ch_d;
      issue_act_q <= issue_act_d;
      rom_addr_q  <= rom_addr_d;
      pend_q      <= pend_d;
      cfg_err_q   <= cfg_err_d;
      if (accept & ~bad_req) begin
        pend_ch_q   <= cfg_ch;
        pend_en_q   <= cfg_en;
        pend_clr_q  <= cfg_clr;
        pend_step_q <= cfg_step;
        pend_poff_q <= cfg_poff;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    localparam logic CH = (gi != 0);

    logic              issue, apply, clr_now, cap;
    phase_t            acc_q, acc_d, step_q, step_d;
    logic [ADDR_W-1:0] poff_q, poff_d, base, poff_eff, int_sum;
    logic              en_q, en_d, valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [FRAC_W:0]   frac_sum;

    assign issue    = (rom_ch_q != CH);
    assign apply    = issue & pend_q & (pend_ch_q == CH);
    assign clr_now  = apply & pend_clr_q;
    assign cap      = issue_act_q & (rom_ch_q == CH);
    assign frac_sum = {1'b0, acc_q.fp} + {1'b0, step_q.fp};
    // An apply edge already issues with the new offset (and zero phase on clear).
    assign base     = clr_now ? '0 : acc_q.ip;
    assign poff_eff = apply ? pend_poff_q : poff_q;
    assign en_eff[gi] = apply ? pend_en_q : en_q;

    dds_mod_add #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_acc_add (
      .a_i  (acc_q.ip),
      .b_i  (step_q.ip),
      .cin_i(frac_sum[FRAC_W]),
      .sum_o(int_sum)
    );

    dds_mod_add #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_off_add (
      .a_i  (base),
      .b_i  (poff_eff),
      .cin_i(1'b0),
      .sum_o(issue_addr[gi])
    );

    // The update at an apply edge still uses the old step; the new one takes over next slot.
    always_comb begin
      acc_d  = acc_q;
      step_d = step_q;
      poff_d = poff_q;
      en_d   = en_q;
      if (clr_now) begin
        acc_d = '0;
      end else if (issue & en_eff[gi]) begin
        acc_d = {int_sum, frac_sum[FRAC_W-1:0]};
      end
      if (apply) begin
        step_d = pend_step_q;
        poff_d = pend_poff_q;
        en_d   = pend_en_q;
      end
      valid_d = cap;
      data_d  = cap ? rom_rd_data : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q   <= '0;
        step_q  <= '0;
        poff_q  <= '0;
        en_q    <= 1'b0;
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        acc_q   <= acc_d;
        step_q  <= step_d;
        poff_q  <= poff_d;
        en_q    <= en_d;
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign valid_vec[gi] = valid_q;
    assign data_vec[gi]  = data_q;
  end

  assign rom_addr  = rom_addr_q;
  assign cfg_err   = cfg_err_q;
  assign ch0_data  = data_vec[0];
  assign ch1_data  = data_vec[1];
  assign ch0_valid = valid_vec[0];
  assign ch1_valid = valid_vec[1];
endmodule

// File: tb/tb_dds_rom_sequencer.sv
// Randomized scoreboard bench for dds_rom_sequencer against a phase-arithmetic reference model.
module tb_dds_rom_sequencer;
  localparam int DEPTH  = 400;
  localparam int PH_MOD = DEPTH * 256;

  logic        clk;
  logic        rst_n;
  logic [8:0]  rom_addr;
  logic [7:0]  rom_rd_data;
  logic        cfg_valid, cfg_ready, cfg_ch, cfg_en, cfg_clr, cfg_err;
  logic [16:0] cfg_step;
  logic [8:0]  cfg_poff;
  logic [7:0]  ch0_data, ch1_data;
  logic        ch0_valid, ch1_valid;

  logic [7:0]  rom_mem [0:511];
  assign rom_rd_data = rom_mem[rom_addr];

  dds_rom_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rom_addr   (rom_addr),
    .rom_rd_data(rom_rd_data),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_en     (cfg_en),
    .cfg_clr    (cfg_clr),
    .cfg_step   (cfg_step),
    .cfg_poff   (cfg_poff),
    .cfg_err    (cfg_err),
    .ch0_data   (ch0_data),
    .ch1_data   (ch1_data),
    .ch0_valid  (ch0_valid),
    .ch1_valid  (ch1_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase kept as an integer count of 1/256 ROM steps.
  typedef struct { int tag; int data; } exp_t;
  exp_t exq0[$];
  exp_t exq1[$];

  int   m_ecnt = 0;
  int   m_phase[2] = '{0, 0};
  int   m_step[2]  = '{0, 0};
  int   m_poff[2]  = '{0, 0};
  bit   m_en[2]    = '{0, 0};
  int   m_last[2]  = '{0, 0};
  bit   p_valid = 0, p_ch = 0, p_en = 0, p_clr = 0;
  int   p_step = 0, p_poff = 0;
  bit   prev_act = 0;
  int   prev_ch = 0, prev_addr = 0;
  int   exp_addr = 0;
  bit   exp_err = 0;
  int   m_k, m_base, m_addr;
  bit   m_accept, m_apply;
  exp_t m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ecnt = 0;
      for (int i = 0; i < 2; i++) begin
        m_phase[i] = 0; m_step[i] = 0; m_poff[i] = 0; m_en[i] = 0; m_last[i] = 0;
      end
      p_valid = 0; prev_act = 0; exp_addr = 0; exp_err = 0;
      exq0.delete();
      exq1.delete();
    end else begin
      if (prev_act) begin
        m_e.tag  = m_ecnt;
        m_e.data = int'(rom_mem[prev_addr]);
        if (prev_ch == 0) exq0.push_back(m_e);
        else exq1.push_back(m_e);
      end
      m_k      = m_ecnt % 2;
      m_accept = cfg_valid && !p_valid;
      m_apply  = p_valid && (int'(p_ch) == m_k);
      if (m_apply) begin
        m_poff[m_k] = p_poff;
        m_en[m_k]   = p_en;
      end
      m_base = (m_apply && p_clr) ? 0 : m_phase[m_k] / 256;
      m_addr = (m_base + m_poff[m_k]) % DEPTH;
      if (m_apply && p_clr) m_phase[m_k] = 0;
      else if (m_en[m_k]) m_phase[m_k] = (m_phase[m_k] + m_step[m_k]) % PH_MOD;
      if (m_apply) begin
        m_step[m_k] = p_step;
        p_valid     = 0;
      end
      exp_err = 0;
      if (m_accept) begin
        if (int'(cfg_step[16:8]) >= DEPTH || int'(cfg_poff) >= DEPTH) begin
          exp_err = 1;
        end else begin
          p_valid = 1; p_ch = cfg_ch; p_en = cfg_en; p_clr = cfg_clr;
          p_step = int'(cfg_step); p_poff = int'(cfg_poff);
        end
      end
      prev_act  = m_en[m_k];
      prev_ch   = m_k;
      prev_addr = m_addr;
      exp_addr  = m_addr;
      m_ecnt++;
    end
  end

  task automatic mon_ch(input int n, input logic v, input logic [7:0] d);
    exp_t e;
    int   sz;
    int   now;
    now = m_ecnt - 1;
    sz  = (n == 0) ? exq0.size() : exq1.size();
    if (sz > 0) e = (n == 0) ? exq0[0] : exq1[0];
    if (v === 1'b1) begin
      if (sz == 0) begin
        chk($sformatf("ch%0d_valid_unexpected", n), 32'(v), 32'd0);
      end else begin
        if (n == 0) void'(exq0.pop_front());
        else void'(exq1.pop_front());
        chk($sformatf("ch%0d_sample_edge", n), 32'(now), 32'(e.tag));
        m_last[n] = e.data;
      end
    end else if (sz > 0 && e.tag <= now) begin
      if (n == 0) void'(exq0.pop_front());
      else void'(exq1.pop_front());
      chk($sformatf("ch%0d_valid_missing", n), 32'(v), 32'd1);
    end
    chk($sformatf("ch%0d_data", n), 32'(d), 32'(m_last[n]));
  endtask

  always @(negedge clk) begin
    chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
    chk("cfg_ready", 32'(cfg_ready), 32'(!p_valid));
    chk("cfg_err", 32'(cfg_err), 32'(exp_err));
    mon_ch(0, ch0_valid, ch0_data);
    mon_ch(1, ch1_valid, ch1_data);
  end

  task automatic check_idle(input string tag);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
    chk({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
    chk({tag, "_ch0_data"}, 32'(ch0_data), 32'd0);
    chk({tag, "_ch1_data"}, 32'(ch1_data), 32'd0);
    chk({tag, "_ch0_valid"}, 32'(ch0_valid), 32'd0);
    chk({tag, "_ch1_valid"}, 32'(ch1_valid), 32'd0);
  endtask

  // Returns right after the accepting edge with cfg_valid still high.
  task automatic send_cfg(input int ch, input int en, input int clr,
                          input int sint, input int sfrac, input int poff);
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_ch    = ch[0];
    cfg_en    = en[0];
    cfg_clr   = clr[0];
    cfg_step  = 17'((sint << 8) | sfrac);
    cfg_poff  = 9'(poff);
    while (!ok && n < 20) begin
      ok = cfg_ready;
      @(posedge clk);
      n++;
      if (!ok) @(negedge clk);
    end
    chk("cfg_accept_timeout", 32'(ok), 32'd1);
    $display("cfg ch=%0d en=%0d clr=%0d step=%0d.%0d poff=%0d taken after %0d cycles",
             ch, en, clr, sint, sfrac, poff, n);
  endtask

  task automatic run(input int n);
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  int r_int, r_frac, r_poff;

  initial begin
    rst_n = 1'b1;
    cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_en = 1'b0; cfg_clr = 1'b0;
    cfg_step = '0; cfg_poff = '0;
    for (int i = 0; i < 512; i++) rom_mem[i] = 8'($urandom);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    #2 rst_n = 1'b1;

    // ch0 step 1.0 through a full wrap of the table
    send_cfg(0, 1, 1, 1, 0, 0);
    run(900);

    // ch0 step 3.5, ch1 step 1.0 offset 200
    send_cfg(0, 1, 1, 3, 128, 0);
    send_cfg(1, 1, 1, 1, 0, 200);
    run(500);

    // step 399.5 drives the integer sum past DEPTH with a fractional carry
    send_cfg(1, 1, 1, 399, 128, 0);
    run(100);

    // rejected requests
    send_cfg(0, 1, 0, 400, 0, 0);
    run(4);
    send_cfg(1, 1, 0, 1, 0, 450);
    run(10);

    // back-to-back: second request waits for the first to apply, then clears
    send_cfg(0, 1, 0, 2, 64, 5);
    send_cfg(1, 1, 1, 7, 0, 77);
    run(30);

    // freeze a channel with en=0
    send_cfg(0, 0, 0, 9, 0, 3);
    run(20);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        r_int  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(400, 511)) : int'($urandom_range(0, 399));
        r_frac = int'($urandom_range(0, 255));
        r_poff = ($urandom_range(0, 15) == 0) ? int'($urandom_range(400, 511)) : int'($urandom_range(0, 399));
        cfg_valid = 1'b1;
        cfg_ch    = 1'($urandom_range(0, 1));
        cfg_en    = ($urandom_range(0, 4) != 0);
        cfg_clr   = ($urandom_range(0, 3) == 0);
        cfg_step  = 17'((r_int << 8) | r_frac);
        cfg_poff  = 9'(r_poff);
      end else begin
        cfg_valid = 1'b0;
      end
    end
    run(10);

    // reset while a config is pending
    send_cfg(0, 1, 1, 5, 0, 10);
    #2 rst_n = 1'b0;
    cfg_valid = 1'b0;
    #1 check_idle("midrst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    run(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
